// File: rtl/inv_uart_rx.sv
// Inverted-polarity UART receiver, 8 data bits, no parity, one stop bit.
// The serial line idles low, the start bit is high, data bits arrive inverted
// (LSB first) and the stop bit is low. Each bit is sampled once at its middle,
// timed by a bit timer running from a single clock. Reset is synchronous and
// active-high.
module inv_uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    // The timer only has to count to CLKS_PER_BIT-1, so its width follows that
    // terminal value. CLKS_PER_BIT is expected to be even and at least 4, so
    // the half-bit terminal value is an exact midpoint.
    localparam int TIMER_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] HALF_LAST  = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_LAST  = TIMER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Two-flop synchronizer for the asynchronous serial line.
    logic sync1_r;
    logic rx_s_r;

    // Receiver state.
    state_t             state_r;
    logic [TIMER_W-1:0] timer_r;
    logic [2:0]         bit_idx_r;
    logic [7:0]         shift_r;

    // Registered outputs.
    logic [7:0] data_out_r;
    logic       data_valid_r;
    logic       frame_err_r;
    logic       busy_r;

    // Sample points: middle of the start bit, then one full bit period apart.
    logic half_done_s;
    logic full_done_s;

    assign half_done_s = (timer_r == HALF_LAST);
    assign full_done_s = (timer_r == FULL_LAST);

    // Bring rx_in into the clk domain; only the second flop is ever used.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            rx_s_r  <= 1'b0;
        end else begin
            sync1_r <= rx_in;
            rx_s_r  <= sync1_r;
        end
    end

    // Receiver FSM: start detection, mid-bit sampling, stop check, output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            timer_r      <= TIMER_ZERO;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            data_out_r   <= 8'h00;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;

            if (!ena) begin
                // Drop any partial frame; data_out keeps the last good byte.
                state_r   <= IDLE;
                timer_r   <= TIMER_ZERO;
                bit_idx_r <= 3'd0;
                busy_r    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        timer_r   <= TIMER_ZERO;
                        bit_idx_r <= 3'd0;
                        if (rx_s_r) begin
                            state_r <= START;
                            busy_r  <= 1'b1;
                        end else begin
                            busy_r  <= 1'b0;
                        end
                    end

                    START: begin
                        if (half_done_s) begin
                            timer_r   <= TIMER_ZERO;
                            bit_idx_r <= 3'd0;
                            if (rx_s_r) begin
                                // Start bit still present at its middle: genuine frame.
                                state_r <= DATA;
                                shift_r <= 8'h00;
                            end else begin
                                // Too short to be a start bit; treat as a glitch.
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            timer_r <= timer_r + TIMER_ONE;
                        end
                    end

                    DATA: begin
                        if (full_done_s) begin
                            timer_r            <= TIMER_ZERO;
                            // Line carries inverted data; restore true polarity.
                            shift_r[bit_idx_r] <= ~rx_s_r;
                            if (bit_idx_r == 3'd7) begin
                                state_r   <= STOP;
                                bit_idx_r <= 3'd0;
                            end else begin
                                bit_idx_r <= bit_idx_r + 3'd1;
                            end
                        end else begin
                            timer_r <= timer_r + TIMER_ONE;
                        end
                    end

                    STOP: begin
                        if (full_done_s) begin
                            timer_r <= TIMER_ZERO;
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            if (!rx_s_r) begin
                                data_out_r   <= shift_r;
                                data_valid_r <= 1'b1;
                            end else begin
                                frame_err_r  <= 1'b1;
                            end
                        end else begin
                            timer_r <= timer_r + TIMER_ONE;
                        end
                    end

                    default: begin
                        state_r   <= IDLE;
                        timer_r   <= TIMER_ZERO;
                        bit_idx_r <= 3'd0;
                        busy_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

endmodule

// File: doc/inv_uart_rx.md
INV_UART_RX -- requirements
Module: inv_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; SHALL be even and >= 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ena  input  1  enable; 0 SHALL force the receiver idle.
REQ-005 rx_in  input  1  inverted-polarity serial line: idle 0, start bit 1, data bits inverted, stop bit 0; asynchronous to clk.
REQ-006 data_out  output  8  last correctly framed byte, true polarity.
REQ-007 data_valid  output  1  one-cycle pulse: data_out newly updated.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit invalid.
REQ-009 busy  output  1  high whenever state != IDLE.

Function
REQ-010 rx_in SHALL pass through a 2-flop synchronizer; all decisions use the second flop (rx_s).
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP; bit-timer counter and 3-bit bit index.
REQ-012 IDLE: on rx_s==1 with ena==1 -> START, timer cleared.
REQ-013 START: after CLKS_PER_BIT/2 cycles re-sample rx_s; 1 -> DATA, timer and bit index cleared; 0 -> IDLE (false start, no pulse).
REQ-014 DATA: every CLKS_PER_BIT cycles sample ~rx_s into bit[index], LSB first; after bit 7 -> STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles sample rx_s; 0 -> load data_out, data_valid=1 next cycle; 1 -> frame_err=1 next cycle, data_out unchanged; either way -> IDLE.
REQ-016 Latency: first rx_in=1 sampled at edge k -> stop sample at edge k+N, N = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (154 for default); pulse visible in cycle after edge k+N.
REQ-017 data_valid and frame_err SHALL never assert together and SHALL each last exactly one cycle.
REQ-018 Back-to-back frames: IDLE SHALL accept a new start bit in the cycle immediately after returning from STOP.
REQ-019 rx_in changes within a frame other than at sample points SHALL be ignored (single mid-bit sample, no majority vote).
REQ-020 ena deasserted in any state: next state IDLE, partial byte discarded, no pulses, data_out held.
REQ-021 Timer SHALL not wrap; it is cleared at every sample point and state change.

Reset
REQ-022 rst=1 at a clock edge: state IDLE, timer/index 0, synchronizer flops 0, data_out=0x00, data_valid=0, frame_err=0, busy=0, from the following cycle.
REQ-023 rst SHALL override ena and any in-progress frame; no pulse SHALL emit from an aborted frame.
REQ-024 After rst deasserts, first start bit SHALL be honored with REQ-016 latency.

Verification
REQ-025 Byte 0xA5, default param, line inverted (start=1, bits ~1,~0,~1,~0,~0,~1,~0,~1, stop=0) -> data_out=0xA5, data_valid one cycle at k+154, frame_err=0.
REQ-026 3-cycle rx_in=1 glitch from idle -> busy high ~CLKS_PER_BIT/2+2 cycles, then IDLE; no data_valid, no frame_err, data_out unchanged.
REQ-027 Frame 0x3C with rx_in=1 during stop -> frame_err one cycle, data_valid=0, data_out keeps previous 0xA5.
REQ-028 Back-to-back 0x00 then 0xFF, no idle gap -> two data_valid pulses 10*CLKS_PER_BIT cycles apart, values 0x00 then 0xFF.
REQ-029 rst pulsed mid-DATA of frame 0x55 -> outputs 0 next cycle, no pulse; following frame 0x81 received correctly.
REQ-030 ena=0 during bit 4 of frame 0x77 -> busy=0 next cycle, no pulse; ena=1 and frame 0x12 -> data_out=0x12.
